otter_bus_demux5: RTL and testbench
===================================

Name: otter_bus_demux5

Overview:
- Single-initiator, five-responder bus router for the OTTER multicycle core.
- Takes one CPU load/store request and decodes the address to a one-hot slave select.
- Forwards the request to the selected slave and waits for its ready.
- Returns that slave's read data, or an error, to the CPU as a single-cycle response.
- Sits between the core's memory/MMIO request port and the data memory and peripheral blocks. It is the distribution end of the path whose result-select side the core's result muxes implement.

Parameters:
- TAG0, 4'h0, Addr[31:28] value mapped to slave 0 (data memory)
- TAG1, 4'h1, Addr[31:28] value mapped to slave 1
- TAG2, 4'h2, Addr[31:28] value mapped to slave 2
- TAG3, 4'h3, Addr[31:28] value mapped to slave 3
- TAG4, 4'hF, Addr[31:28] value mapped to slave 4 (MMIO)
- TIMEOUT, 15, max ACCESS cycles without slave ready before error (legal range 1..255)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  synchronous active-low reset
- ReqValid  in  1  CPU request present
- ReqReady  out  1  block can accept a request (1 only in IDLE)
- ReqAddr  in  32  byte address
- ReqWe  in  1  1 = store, 0 = load
- ReqWData  in  32  store data
- ReqSize  in  2  00 byte, 01 half, 10 word; passed through unmodified
- RspValid  out  1  one-cycle response strobe
- RspRData  out  32  load data (0 for stores and errors)
- RspErr  out  1  unmapped address or timeout; valid with RspValid
- SlvSel  out  5  one-hot slave select, held for the whole access
- SlvAddr  out  32  latched address
- SlvWe  out  1  latched write enable, gated by SlvSel!=0
- SlvWData  out  32  latched store data
- SlvSize  out  2  latched size
- SlvReady  in  5  per-slave completion; only the selected bit is observed
- SlvRData  in  160  packed read data, slave i at [32*i+31:32*i]

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Single outstanding request; no pipelining.
- Reset (RST_N=0 at a rising edge):
  - state returns to IDLE; SlvSel, SlvWe, RspValid, RspErr = 0.
  - RspRData, SlvAddr, SlvWData, SlvSize = 0; timeout counter = 0.
  - Takes effect from any state. An in-flight access is abandoned with no RspValid.
  - ReqValid is ignored on any cycle where RST_N=0.
- IDLE:
  - ReqReady=1.
  - On ReqValid=1: latch Addr/We/WData/Size and decode Addr[31:28] against TAG0..TAG4.
  - If several tags match, the lowest index wins.
  - On a match: go to ACCESS, SlvSel=onehot(index) from the next cycle, counter cleared.
  - No match: go to RESP with RspErr=1, RspRData=0, SlvSel stays 0 (no slave ever sees the access).
- ACCESS:
  - ReqReady=0; Slv* outputs stable; counter increments each cycle.
  - SlvReady[sel]=1: capture SlvRData[sel] if load, else 0; RspErr=0; go to RESP; SlvSel=0 next cycle.
  - counter==TIMEOUT-1 with no ready: go to RESP with RspErr=1, RspRData=0, SlvSel=0.
  - Ready in the same cycle as the timeout wins (normal response).
  - SlvReady bits of unselected slaves are ignored, including spurious pulses.
- RESP:
  - RspValid=1 for exactly one cycle; ReqReady=0; then IDLE.
  - RspRData and RspErr hold their values until the next response.
  - A new request is accepted no earlier than the cycle after RESP.
- Latency, counted as cycles after the acceptance edge:
  - Mapped access, slave ready in first ACCESS cycle: RspValid at +2.
  - Each extra wait cycle adds 1.
  - Unmapped access: RspValid at +1.
  - Timeout: RspValid at +TIMEOUT+1.
- Counter width is 8 bits and never wraps: it saturates and is cleared on entry to ACCESS.

Test Plan:
- Reset then load, Addr=0x0000_0040 → SlvSel=00001 at +1; SlvRData[31:0]=0xDEADBEEF with SlvReady[0]=1 at +1 → RspValid=1, RspRData=0xDEADBEEF, RspErr=0 at +2.
- Store, Addr=0xF000_0010, WData=0x12345678, Size=10 → SlvSel=10000, SlvWe=1, SlvWData=0x12345678; SlvReady[4] after 3 wait cycles → RspValid at +5, RspRData=0.
- Load, Addr=0x7000_0000 (unmapped) → SlvSel stays 00000, RspValid=1, RspErr=1 at +1, ReqReady back to 1 at +2.
- Load to slave 2 with SlvReady held 0 and TIMEOUT=15 → RspErr=1 at +16, SlvSel=0 from then. A repeat run with SlvReady[2] asserted on the 15th ACCESS cycle → RspErr=0.
- Load to slave 1, SlvReady=11101 (selected bit 0) for 4 cycles, then 00010 → no early response; RspValid at +6 with slave-1 data.
- RST_N=0 on the second ACCESS cycle → next cycle IDLE, SlvSel=0, ReqReady=1; no RspValid ever issued for the aborted request.

Source files
------------

// File: rtl/otter_bus_demux5.sv
// Single-initiator, five-responder bus router for the OTTER core: decodes a
// load/store to a one-hot slave select, waits for that slave, returns data or error.
module otter_bus_demux5 #(
  parameter logic [3:0]  TAG0    = 4'h0,
  parameter logic [3:0]  TAG1    = 4'h1,
  parameter logic [3:0]  TAG2    = 4'h2,
  parameter logic [3:0]  TAG3    = 4'h3,
  parameter logic [3:0]  TAG4    = 4'hF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic [31:0]  ReqAddr,
  input  logic         ReqWe,
  input  logic [31:0]  ReqWData,
  input  logic [1:0]   ReqSize,
  output logic         RspValid,
  output logic [31:0]  RspRData,
  output logic         RspErr,
  output logic [4:0]   SlvSel,
  output logic [31:0]  SlvAddr,
  output logic         SlvWe,
  output logic [31:0]  SlvWData,
  output logic [1:0]   SlvSize,
  input  logic [4:0]   SlvReady,
  input  logic [159:0] SlvRData
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [4:0]  r_sel;
  logic [31:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic [7:0]  r_cnt;

  logic [4:0]  w_dec_sel;
  logic [31:0] w_sel_rdata;
  logic        w_sel_ready;
  logic        w_timeout;

  // Priority chain: when several tags are equal the lowest slave index wins.
  always_comb begin
    w_dec_sel = 5'b00000;
    if      (ReqAddr[31:28] == TAG0) w_dec_sel = 5'b00001;
    else if (ReqAddr[31:28] == TAG1) w_dec_sel = 5'b00010;
    else if (ReqAddr[31:28] == TAG2) w_dec_sel = 5'b00100;
    else if (ReqAddr[31:28] == TAG3) w_dec_sel = 5'b01000;
    else if (ReqAddr[31:28] == TAG4) w_dec_sel = 5'b10000;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      if (r_sel[i]) w_sel_rdata = w_sel_rdata | SlvRData[32*i +: 32];
    end
  end

  assign w_sel_ready = |(SlvReady & r_sel);
  assign w_timeout   = (r_cnt == CntLast);

  // NOTE: state is updated with non-blocking assignments; reset is synchronous.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_sel       <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_size      <= '0;
      r_cnt       <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ReqValid) begin
            r_addr      <= ReqAddr;
            r_we        <= ReqWe;
            r_wdata     <= ReqWData;
            r_size      <= ReqSize;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            if (|w_dec_sel) begin
              r_sel   <= w_dec_sel;
              r_state <= ST_ACCESS;
            end else begin
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
          // A ready arriving on the timeout cycle still completes normally.
          if (w_sel_ready) begin
            r_rsp_rdata <= r_we ? 32'h0 : w_sel_rdata;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_sel       <= '0;
            r_state     <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_sel       <= '0;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign ReqReady = r_req_ready;
  assign RspValid = r_rsp_valid;
  assign RspRData = r_rsp_rdata;
  assign RspErr   = r_rsp_err;
  assign SlvSel   = r_sel;
  assign SlvAddr  = r_addr;
  assign SlvWe    = r_we & (|r_sel);
  assign SlvWData = r_wdata;
  assign SlvSize  = r_size;

endmodule

// File: tb/tb_otter_bus_demux5.sv
// Self-checking bench for otter_bus_demux5: per-transaction timeline model
// (response cycle, error and data computed arithmetically) compared every cycle.
module tb_otter_bus_demux5;

  localparam int TMO = 15;

  logic         CLK;
  logic         RST_N;
  logic         ReqValid;
  logic         ReqReady;
  logic [31:0]  ReqAddr;
  logic         ReqWe;
  logic [31:0]  ReqWData;
  logic [1:0]   ReqSize;
  logic         RspValid;
  logic [31:0]  RspRData;
  logic         RspErr;
  logic [4:0]   SlvSel;
  logic [31:0]  SlvAddr;
  logic         SlvWe;
  logic [31:0]  SlvWData;
  logic [1:0]   SlvSize;
  logic [4:0]   SlvReady;
  logic [159:0] SlvRData;

  otter_bus_demux5 #(
    .TAG0(4'h0), .TAG1(4'h1), .TAG2(4'h2), .TAG3(4'h3), .TAG4(4'hF), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr), .ReqWe(ReqWe),
    .ReqWData(ReqWData), .ReqSize(ReqSize),
    .RspValid(RspValid), .RspRData(RspRData), .RspErr(RspErr),
    .SlvSel(SlvSel), .SlvAddr(SlvAddr), .SlvWe(SlvWe), .SlvWData(SlvWData),
    .SlvSize(SlvSize), .SlvReady(SlvReady), .SlvRData(SlvRData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Expected outputs for the current cycle, plus values held between responses.
  bit          chk_en = 1'b0;
  logic        e_req_ready, e_rsp_valid, e_err, e_we;
  logic [4:0]  e_sel;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [1:0]  e_size;
  logic [31:0] h_addr = '0, h_wdata = '0, h_rdata = '0;
  logic [1:0]  h_size = '0;
  logic        h_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("ReqReady", 32'(ReqReady), 32'(e_req_ready));
      check("RspValid", 32'(RspValid), 32'(e_rsp_valid));
      check("RspRData", RspRData, e_rdata);
      check("RspErr",   32'(RspErr),   32'(e_err));
      check("SlvSel",   32'(SlvSel),   32'(e_sel));
      check("SlvWe",    32'(SlvWe),    32'(e_we));
      check("SlvAddr",  SlvAddr,       e_addr);
      check("SlvWData", SlvWData,      e_wdata);
      check("SlvSize",  32'(SlvSize),  32'(e_size));
    end
  end

  function automatic logic [3:0] tag_of(input int i);
    case (i)
      0: return 4'h0;
      1: return 4'h1;
      2: return 4'h2;
      3: return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic int idx_of(input logic [3:0] nib);
    for (int i = 0; i < 5; i++) if (nib == tag_of(i)) return i;
    return -1;
  endfunction

  task automatic set_idle_exp();
    e_req_ready = 1'b1;
    e_rsp_valid = 1'b0;
    e_sel       = '0;
    e_we        = 1'b0;
    e_addr      = h_addr;
    e_wdata     = h_wdata;
    e_size      = h_size;
    e_rdata     = h_rdata;
    e_err       = h_err;
  endtask

  task automatic idle_cycle();
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    ReqAddr  = $urandom;
    ReqWData = $urandom;
    ReqWe    = 1'($urandom);
    ReqSize  = 2'($urandom);
    SlvReady = 5'($urandom);
    set_idle_exp();
  endtask

  // k = ACCESS-cycle index (0-based) on which the selected slave raises ready;
  // k >= TMO means never. reset_at > 0 drops RST_N during that cycle.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [1:0] size, input logic [31:0] sdata, input int k,
                         input bit spur_all, input int reset_at,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output logic [4:0] sel1);
    int          idx, resp_t, last_t;
    bit          mapped;
    logic        err_n;
    logic [31:0] rd_n;
    idx    = idx_of(addr[31:28]);
    mapped = (idx >= 0);
    resp_t = !mapped ? 1 : ((k < TMO) ? k + 2 : TMO + 1);
    err_n  = !mapped || (k >= TMO);
    rd_n   = (!err_n && !we) ? sdata : 32'h0;
    last_t = (reset_at > 0) ? reset_at : resp_t;
    lat = -1; rdata = '0; err = 1'b0; sel1 = '0;

    @(posedge CLK); #1;
    ReqValid = 1'b1; ReqAddr = addr; ReqWe = we; ReqWData = wdata; ReqSize = size;
    SlvReady = 5'($urandom);
    SlvRData = {$urandom, $urandom, $urandom, $urandom, $urandom};
    if (mapped) SlvRData[32*idx +: 32] = sdata;
    set_idle_exp();
    @(negedge CLK);

    for (int t = 1; t <= last_t; t++) begin
      @(posedge CLK); #1;
      ReqValid = 1'($urandom);
      ReqAddr  = $urandom;
      ReqWe    = 1'($urandom);
      ReqWData = $urandom;
      ReqSize  = 2'($urandom);
      SlvReady = spur_all ? 5'b11111 : 5'($urandom);
      if (mapped) SlvReady[idx] = (t - 1 == k);
      RST_N = !(t == reset_at);
      e_req_ready = 1'b0;
      e_rsp_valid = (t == resp_t);
      e_sel       = (mapped && t < resp_t) ? 5'(1 << idx) : 5'b0;
      e_we        = (e_sel != 5'b0) && we;
      e_addr      = addr;
      e_wdata     = wdata;
      e_size      = size;
      e_rdata     = (t == resp_t) ? rd_n : h_rdata;
      e_err       = (t == resp_t) ? err_n : h_err;
      @(negedge CLK);
      if (t == 1) sel1 = SlvSel;
      if (RspValid && lat < 0) begin lat = t; rdata = RspRData; err = RspErr; end
    end

    if (reset_at > 0) begin
      h_addr = '0; h_wdata = '0; h_size = '0; h_rdata = '0; h_err = 1'b0;
      for (int t = 0; t < 4; t++) begin
        @(posedge CLK); #1;
        RST_N    = 1'b1;
        ReqValid = 1'b0;
        SlvReady = 5'($urandom);
        set_idle_exp();
        @(negedge CLK);
        if (RspValid && lat < 0) lat = reset_at + 1 + t;
      end
    end else begin
      h_addr = addr; h_wdata = wdata; h_size = size; h_rdata = rd_n; h_err = err_n;
    end
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  logic [4:0]  s1;

  initial begin
    RST_N    = 1'b0;
    ReqValid = 1'b1;
    ReqAddr  = 32'h0000_0040;
    ReqWe    = 1'b0;
    ReqWData = '0;
    ReqSize  = 2'b10;
    SlvReady = '0;
    SlvRData = '0;

    // ReqValid held high through reset must not start an access.
    @(posedge CLK); #1;
    set_idle_exp();
    chk_en = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N    = 1'b1;
    ReqValid = 1'b0;
    idle_cycle();

    run_txn(32'h0000_0040, 1'b0, 32'h0, 2'b10, 32'hDEAD_BEEF, 0, 1'b0, 0, lat, rd, er, s1);
    check("t1_lat",   32'(lat), 32'd2);
    check("t1_rdata", rd,       32'hDEAD_BEEF);
    check("t1_err",   32'(er),  32'd0);
    check("t1_sel",   32'(s1),  32'b00001);
    idle_cycle();

    run_txn(32'hF000_0010, 1'b1, 32'h1234_5678, 2'b10, 32'hCAFE_F00D, 3, 1'b0, 0, lat, rd, er, s1);
    check("t2_lat",   32'(lat), 32'd5);
    check("t2_rdata", rd,       32'h0);
    check("t2_sel",   32'(s1),  32'b10000);

    run_txn(32'h7000_0000, 1'b0, 32'h0, 2'b10, 32'h1111_2222, 0, 1'b0, 0, lat, rd, er, s1);
    check("t3_lat",   32'(lat), 32'd1);
    check("t3_err",   32'(er),  32'd1);
    check("t3_sel",   32'(s1),  32'b00000);
    idle_cycle();

    run_txn(32'h2000_0100, 1'b0, 32'h0, 2'b10, 32'h5555_AAAA, 255, 1'b0, 0, lat, rd, er, s1);
    check("t4_lat",   32'(lat), 32'd16);
    check("t4_err",   32'(er),  32'd1);
    check("t4_rdata", rd,       32'h0);
    run_txn(32'h2000_0100, 1'b0, 32'h0, 2'b10, 32'h5555_AAAA, 14, 1'b0, 0, lat, rd, er, s1);
    check("t4b_lat",   32'(lat), 32'd16);
    check("t4b_err",   32'(er),  32'd0);
    check("t4b_rdata", rd,       32'h5555_AAAA);

    run_txn(32'h1000_0008, 1'b0, 32'h0, 2'b01, 32'hA5A5_0001, 4, 1'b1, 0, lat, rd, er, s1);
    check("t5_lat",   32'(lat), 32'd6);
    check("t5_rdata", rd,       32'hA5A5_0001);
    check("t5_sel",   32'(s1),  32'b00010);

    run_txn(32'h3000_0000, 1'b0, 32'h0, 2'b10, 32'h7777_8888, 10, 1'b0, 2, lat, rd, er, s1);
    check("t6_no_rsp", 32'(lat), 32'hFFFF_FFFF);

    for (int n = 0; n < 60; n++) begin
      int          pick, k;
      logic [3:0]  nib;
      pick = $urandom_range(0, 6);
      nib  = (pick < 5) ? tag_of(pick) : 4'($urandom);
      k    = $urandom_range(0, 9);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: k = TMO - 2;
          1: k = TMO - 1;
          2: k = TMO;
          default: k = 255;
        endcase
      end
      run_txn({nib, 28'($urandom)}, 1'($urandom), $urandom, 2'($urandom_range(0, 2)),
              $urandom, k, 1'($urandom_range(0, 3) == 0), 0, lat, rd, er, s1);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();
    @(negedge CLK);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
